// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: round-robin between two
// requesters, with a zero-fill clear sequence after reset and on request.
module regfile_write_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDRW = 5,
  parameter int unsigned NREGS = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ClearReq,
  output logic             Busy,
  output logic             ClearDone,
  input  logic             AWrValid,
  input  logic [ADDRW-1:0] AWrAddr,
  input  logic [WIDTH-1:0] AWrData,
  output logic             AWrReady,
  input  logic             BWrValid,
  input  logic [ADDRW-1:0] BWrAddr,
  input  logic [WIDTH-1:0] BWrData,
  output logic             BWrReady,
  output logic [WIDTH-1:0] WriteData,
  output logic [ADDRW-1:0] WriteRegister,
  output logic             RegWrite
);

  typedef enum logic { CLEAR, ARB } state_t;
  typedef enum logic { GRANT_A, GRANT_B } grant_t;

  localparam logic [ADDRW-1:0] LastPtr = ADDRW'(NREGS - 1);

  state_t           state_q, state_d;
  grant_t           last_grant_q, last_grant_d;
  logic [ADDRW-1:0] clr_ptr_q, clr_ptr_d;
  logic             reg_write_q, reg_write_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [ADDRW-1:0] write_reg_q, write_reg_d;
  logic             clear_done_q, clear_done_d;
  logic             a_rdy, b_rdy;

  // Ties go to whichever requester was not granted last.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (state_q == ARB && !ClearReq) begin
      a_rdy = AWrValid && (!BWrValid || last_grant_q == GRANT_B);
      b_rdy = BWrValid && (!AWrValid || last_grant_q == GRANT_A);
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_ptr_d    = clr_ptr_q;
    reg_write_d  = 1'b0;
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      CLEAR: begin
        reg_write_d  = 1'b1;
        write_reg_d  = clr_ptr_q;
        write_data_d = '0;
        if (clr_ptr_q == LastPtr) begin
          clr_ptr_d    = '0;
          state_d      = ARB;
          clear_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ARB: begin
        if (ClearReq) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else if (a_rdy) begin
          reg_write_d  = 1'b1;
          write_reg_d  = AWrAddr;
          write_data_d = AWrData;
          last_grant_d = GRANT_A;
        end else if (b_rdy) begin
          reg_write_d  = 1'b1;
          write_reg_d  = BWrAddr;
          write_data_d = BWrData;
          last_grant_d = GRANT_B;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= CLEAR;
      last_grant_q <= GRANT_B;
      clr_ptr_q    <= '0;
      reg_write_q  <= 1'b0;
      write_data_q <= '0;
      write_reg_q  <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_ptr_q    <= clr_ptr_d;
      reg_write_q  <= reg_write_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign Busy          = (state_q != ARB);
  assign ClearDone     = clear_done_q;
  assign AWrReady      = a_rdy;
  assign BWrReady      = b_rdy;
  assign RegWrite      = reg_write_q;
  assign WriteData     = write_data_q;
  assign WriteRegister = write_reg_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sequences and shares the single write port of the 32x32 register file (WriteData / WriteRegister / RegWrite) between two requesters, A and B.
- After reset, and on demand, runs a clear sequence that writes zero to every register.
- Sits directly in front of regfile's write port. Read ports are not touched.
- Output names match regfile's write-port inputs so the two blocks connect one-to-one.

Parameters:
- WIDTH, 32, data width of WriteData and requester data
- ADDRW, 5, register address width
- NREGS, 32, number of registers the clear sequence covers (addresses 0..NREGS-1)

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst_n  in  1  asynchronous active-low reset
- ClearReq  in  1  request a full register clear; sampled at posedge
- Busy  out  1  high while not in ARB state
- ClearDone  out  1  one-cycle pulse when a clear sequence finishes
- AWrValid  in  1  requester A has a write pending
- AWrAddr  in  ADDRW  requester A target register
- AWrData  in  WIDTH  requester A write data
- AWrReady  out  1  A's write is accepted at this posedge
- BWrValid  in  1  requester B has a write pending
- BWrAddr  in  ADDRW  requester B target register
- BWrData  in  WIDTH  requester B write data
- BWrReady  out  1  B's write is accepted at this posedge
- WriteData  out  WIDTH  to regfile WriteData
- WriteRegister  out  ADDRW  to regfile WriteRegister
- RegWrite  out  1  to regfile RegWrite

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst_n is asynchronous, active-low.
- Reset values (Rst_n low):
  - state=CLEAR, ClrPtr=0, LastGrant=B
  - RegWrite=0, WriteData=0, WriteRegister=0
  - ClearDone=0, Busy=1
- States: CLEAR and ARB.
- CLEAR:
  - AWrReady=BWrReady=0.
  - Each posedge registers RegWrite=1, WriteRegister=ClrPtr, WriteData=0, then ClrPtr increments.
  - On the posedge that issues ClrPtr==NREGS-1: ClrPtr returns to 0, state goes to ARB, and ClearDone=1 for the following cycle only.
  - The first clear write is issued at the first posedge after Rst_n rises.
  - RegWrite is high for exactly NREGS consecutive cycles.
  - ClearReq is ignored while in CLEAR.
- ARB, ready logic (combinational):
  - If ClearReq=1: AWrReady=BWrReady=0. Clear takes priority; the next state is CLEAR with ClrPtr=0.
  - Else, if only one requester is valid, that requester's Ready=1.
  - Else, if both are valid, the one that is not LastGrant gets Ready=1 (round-robin; A wins the first tie after reset).
  - Ready is never high without the matching Valid.
- ARB, on an accepting posedge (Valid&&Ready):
  - Register RegWrite=1, WriteRegister=<X>WrAddr, WriteData=<X>WrData.
  - Set LastGrant=X.
  - With no accept: RegWrite=0; WriteData and WriteRegister hold their previous values.
- Latency:
  - Accept at edge N puts RegWrite high during cycle N..N+1, and regfile commits at edge N+1.
  - A read of that address returns the new value after edge N+1.
- Throughput: one write per cycle. Back-to-back accepts keep RegWrite high continuously.
- Address 0 and the zero register: the arbiter passes writes to address 0 through unmodified; regfile policy handles them.
- Valid/data stability: requesters must hold Valid, Addr and Data until Ready. The arbiter does not buffer.
- Reset mid-operation: asynchronous reset aborts any in-flight write (RegWrite drops immediately) and restarts the full clear sequence.
- ClearReq raised on the same edge a write would be accepted: no write is accepted, and CLEAR starts next.

Test Plan:
1. Release Rst_n, no requests -> RegWrite high for exactly 32 cycles with WriteRegister 0..31 and WriteData=0; ClearDone pulses once; Busy falls the cycle after the last clear write; reading any register gives 0.
2. In ARB, A writes 42 to reg 2 -> AWrReady=1 that cycle; next cycle RegWrite=1, WriteRegister=2, WriteData=42; after the following edge ReadData1=ReadData2=42.
3. A and B both valid continuously (A: reg 3 data 15, B: reg 4 data 7) -> grants alternate A,B,A,B starting with A; RegWrite stays high each cycle.
4. B alone valid for 3 cycles, then A and B both valid -> A wins the tie, since LastGrant=B.
5. ClearReq=1 while A is valid in ARB -> AWrReady=0; 32-cycle clear follows with A stalled; A is accepted the cycle ClearDone is high; its data is present afterward and every other register is 0.
6. Pulse Rst_n low during clear (ClrPtr=10) and during a write -> RegWrite drops asynchronously; the clear restarts at register 0 and completes all 32 writes.
